// File: rtl/alu.sv
// alu: sequential arithmetic/logic unit fed by the microprogrammed control unit.
// Decodes the CU microword, latches operands from ACC/BR, and executes
// single-cycle add/sub/and/or/not/shift ops plus a WIDTH-cycle signed radix-2
// Booth multiply.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   control_signal CU microword (bit 7 acc2alu, 14 br2alu, 22..31 op bits)
//   acc_in, br_in  ACC / BR operand values
//   alu_out        result, or low half of the product
//   mr_out         high half of the product (held by non-multiply ops)
//   flags          {0, illegal, done, busy, V, C, N, Z}
//   busy           multiply in progress (same register as flags[4])
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      control_signal,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] br_in,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] mr_out,
  output logic [7:0]       flags,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  // Op indices within control_signal[31:22]; higher index wins on conflict.
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_OR  = 4'd3, OP_NOT = 4'd4, OP_LSL = 4'd5,
                         OP_LSR = 4'd6, OP_MPY = 4'd7, OP_ASL = 4'd8,
                         OP_ASR = 4'd9;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        a_q, a_d, b_q, b_d;
  logic signed [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0]        q_q, q_d;
  logic                    qm1_q, qm1_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        alu_out_q, alu_out_d, mr_out_q, mr_out_d;
  logic                    z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic                    ill_q, ill_d, done_q, done_d, busy_q, busy_d;

  logic                    acc2alu, br2alu;
  logic [9:0]              ops;
  logic                    multi;
  logic [3:0]              op_idx;
  logic [WIDTH-1:0]        a_eff, b_eff, res;
  logic                    c_new, v_new;
  logic [WIDTH:0]          sum, diff;
  logic signed [WIDTH:0]   m_ext, hi_sum, hi_sh;
  logic [WIDTH-1:0]        q_next;
  logic [2*WIDTH-1:0]      product;
  logic                    unused_cs;

  assign acc2alu = control_signal[7];
  assign br2alu  = control_signal[14];
  assign ops     = control_signal[31:22];
  assign multi   = (ops & (ops - 10'd1)) != 10'd0;
  assign unused_cs = ^{control_signal[21:15], control_signal[13:8], control_signal[6:0]};

  assign a_eff = acc2alu ? acc_in : a_q;
  assign b_eff = br2alu  ? br_in  : b_q;
  assign sum   = {1'b0, a_eff} + {1'b0, b_eff};
  assign diff  = {1'b0, a_eff} - {1'b0, b_eff};

  // Booth iteration: multiplicand is a_q, which already equals the operand
  // seen on the start edge because the latch and the bypass agree there.
  // hi carries one guard bit so -2^(W-1) subtraction cannot overflow.
  assign m_ext = $signed({a_q[WIDTH-1], a_q});
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   hi_sum = hi_q + m_ext;
      2'b10:   hi_sum = hi_q - m_ext;
      default: hi_sum = hi_q;
    endcase
  end
  assign hi_sh   = hi_sum >>> 1;
  assign q_next  = {hi_sum[0], q_q[WIDTH-1:1]};
  assign product = {hi_sh[WIDTH-1:0], q_next};

  always_comb begin
    op_idx = OP_ADD;
    for (int i = 0; i < 10; i++) begin
      if (ops[i]) op_idx = 4'(i);
    end
  end

  always_comb begin
    res   = '0;
    c_new = 1'b0;
    v_new = 1'b0;
    case (op_idx)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        c_new = sum[WIDTH];
        v_new = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != a_eff[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        c_new = ~diff[WIDTH];
        v_new = (a_eff[WIDTH-1] != b_eff[WIDTH-1]) && (res[WIDTH-1] != a_eff[WIDTH-1]);
      end
      OP_AND: res = a_eff & b_eff;
      OP_OR:  res = a_eff | b_eff;
      OP_NOT: res = ~a_eff;
      OP_LSL, OP_ASL: begin
        res   = {a_eff[WIDTH-2:0], 1'b0};
        c_new = a_eff[WIDTH-1];
        v_new = (op_idx == OP_ASL) && (a_eff[WIDTH-1] ^ a_eff[WIDTH-2]);
      end
      OP_LSR: begin
        res   = {1'b0, a_eff[WIDTH-1:1]};
        c_new = a_eff[0];
      end
      OP_ASR: begin
        res   = {a_eff[WIDTH-1], a_eff[WIDTH-1:1]};
        c_new = a_eff[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    alu_out_d = alu_out_q;
    mr_out_d  = mr_out_q;
    z_d       = z_q;
    n_d       = n_q;
    c_d       = c_q;
    v_d       = v_q;
    ill_d     = ill_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc2alu) a_d = acc_in;
        if (br2alu)  b_d = br_in;
        if (ops != 10'd0) begin
          ill_d = multi;
          if (op_idx == OP_MPY) begin
            state_d = S_MUL;
            busy_d  = 1'b1;
            hi_d    = '0;
            q_d     = b_eff;
            qm1_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            alu_out_d = res;
            z_d       = (res == '0);
            n_d       = res[WIDTH-1];
            c_d       = c_new;
            v_d       = v_new;
            done_d    = 1'b1;
          end
        end
      end
      S_MUL: begin
        // Op and latch bits are ignored for the whole multiply, including
        // the completion edge.
        hi_d  = hi_sh;
        q_d   = q_next;
        qm1_d = q_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cnt_d     = '0;
          alu_out_d = product[WIDTH-1:0];
          mr_out_d  = product[2*WIDTH-1:WIDTH];
          z_d       = (product == '0);
          n_d       = product[2*WIDTH-1];
          c_d       = 1'b0;
          v_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      alu_out_q <= '0;
      mr_out_q  <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      ill_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      alu_out_q <= alu_out_d;
      mr_out_q  <= mr_out_d;
      z_q       <= z_d;
      n_q       <= n_d;
      c_q       <= c_d;
      v_q       <= v_d;
      ill_q     <= ill_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign alu_out = alu_out_q;
  assign mr_out  = mr_out_q;
  assign busy    = busy_q;
  assign flags   = {1'b0, ill_q, done_q, busy_q, v_q, c_q, n_q, z_q};

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed testbench for alu with an operation-level reference model
// and a per-cycle compare process, plus hand-computed literal expectations.
module tb_alu;
  localparam logic [31:0] ACC = 32'h1 << 7,  BR  = 32'h1 << 14,
                          ADD = 32'h1 << 22, SUB = 32'h1 << 23,
                          AND = 32'h1 << 24, OR  = 32'h1 << 25,
                          NOT = 32'h1 << 26, LSL = 32'h1 << 27,
                          LSR = 32'h1 << 28, MPY = 32'h1 << 29,
                          ASL = 32'h1 << 30, ASR = 32'h1 << 31;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cs;
  logic [15:0] acc_in, br_in;
  logic [15:0] alu_out, mr_out;
  logic [7:0]  flags;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  alu #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .control_signal(cs), .acc_in(acc_in), .br_in(br_in),
    .alu_out(alu_out), .mr_out(mr_out), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: operation semantics in plain integer arithmetic;
  // a multiply is a countdown with the product computed up front.
  logic [15:0] m_a, m_b, m_alu, m_mr;
  logic        m_z, m_n, m_c, m_v, m_ill, m_done, m_busy;
  logic [31:0] m_prod;
  int          m_rem;

  always @(posedge clk or negedge rst) begin : model
    logic [15:0] ae, be, r;
    logic [9:0]  ops;
    logic        cf, vf;
    int          top, s, sv, p;
    if (!rst) begin
      m_a <= '0; m_b <= '0; m_alu <= '0; m_mr <= '0;
      m_z <= 0; m_n <= 0; m_c <= 0; m_v <= 0; m_ill <= 0; m_done <= 0; m_busy <= 0;
      m_prod <= '0; m_rem <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_alu  <= m_prod[15:0];
          m_mr   <= m_prod[31:16];
          m_z    <= (m_prod == 32'd0);
          m_n    <= m_prod[31];
          m_c    <= 1'b0;
          m_v    <= 1'b0;
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end else begin
        ae = cs[7]  ? acc_in : m_a;
        be = cs[14] ? br_in  : m_b;
        if (cs[7])  m_a <= acc_in;
        if (cs[14]) m_b <= br_in;
        ops = cs[31:22];
        if (ops != 10'd0) begin
          top = 0;
          for (int i = 0; i < 10; i++) if (ops[i]) top = i;
          m_ill <= ($countones(ops) > 1);
          if (top == 7) begin
            p = int'($signed(ae)) * int'($signed(be));
            m_prod <= p;
            m_rem  <= 16;
            m_busy <= 1'b1;
          end else begin
            cf = 1'b0; vf = 1'b0; r = '0;
            case (top)
              0: begin
                s = int'(ae) + int'(be); r = s[15:0]; cf = (s > 65535);
                sv = int'($signed(ae)) + int'($signed(be)); vf = (sv > 32767) || (sv < -32768);
              end
              1: begin
                r = ae - be; cf = (ae >= be);
                sv = int'($signed(ae)) - int'($signed(be)); vf = (sv > 32767) || (sv < -32768);
              end
              2: r = ae & be;
              3: r = ae | be;
              4: r = ~ae;
              5: begin r = ae << 1; cf = ae[15]; end
              6: begin r = ae >> 1; cf = ae[0]; end
              8: begin r = ae << 1; cf = ae[15]; vf = ae[15] ^ ae[14]; end
              default: begin r = $unsigned($signed(ae) >>> 1); cf = ae[0]; end
            endcase
            m_alu <= r; m_z <= (r == 16'd0); m_n <= r[15]; m_c <= cf; m_v <= vf;
            m_done <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst) begin
        chk("rst_alu", {16'd0, alu_out}, 32'd0);
        chk("rst_mr", {16'd0, mr_out}, 32'd0);
        chk("rst_flags", {24'd0, flags}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
      end else begin
        chk("alu_out", {16'd0, alu_out}, {16'd0, m_alu});
        chk("mr_out", {16'd0, mr_out}, {16'd0, m_mr});
        chk("flags", {24'd0, flags},
            {24'd0, 1'b0, m_ill, m_done, m_busy, m_v, m_c, m_n, m_z});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
      end
    end
  end

  task automatic step(input logic [31:0] c, input logic [15:0] a, input logic [15:0] b);
    cs = c; acc_in = a; br_in = b;
    @(negedge clk);
    #1;
  endtask

  task automatic run_mpy(input logic [15:0] a, input logic [15:0] b);
    step(ACC | BR | MPY, a, b);
    repeat (16) step(32'd0, 16'h0, 16'h0);
  endtask

  int n_busy;
  int n_done;

  initial begin
    cs = '0; acc_in = '0; br_in = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("reset_alu", {16'd0, alu_out}, 32'h0);
    chk("reset_flags", {24'd0, flags}, 32'h0);
    rst = 1'b1;
    step(32'd0, 16'h0, 16'h0);

    // Latch then add: 7 + (-3)
    step(ACC, 16'h0007, 16'h0);
    step(BR, 16'h0, 16'hFFFD);
    step(ADD, 16'h0, 16'h0);
    chk("add_res", {16'd0, alu_out}, 32'h0004);
    chk("add_flags", {24'd0, flags}, 32'h24);
    step(32'd0, 16'h0, 16'h0);
    chk("done_clears", {24'd0, flags}, 32'h04);

    // Same-edge bypass, signed overflow, then sub
    step(ACC | BR | ADD, 16'h7FFF, 16'h0001);
    chk("ovf_res", {16'd0, alu_out}, 32'h8000);
    chk("ovf_flags", {24'd0, flags}, 32'h2A);
    step(SUB, 16'h0, 16'h0);
    chk("sub_res", {16'd0, alu_out}, 32'h7FFE);
    chk("sub_flags", {24'd0, flags}, 32'h24);

    // Shifts and not
    step(ACC | ASR, 16'h8004, 16'h0);
    chk("asr_res", {16'd0, alu_out}, 32'hC002);
    chk("asr_flags", {24'd0, flags}, 32'h22);
    step(ACC | LSR, 16'h8001, 16'h0);
    chk("lsr_res", {16'd0, alu_out}, 32'h4000);
    chk("lsr_flags", {24'd0, flags}, 32'h24);
    step(ACC | ASL, 16'h4000, 16'h0);
    chk("asl_res", {16'd0, alu_out}, 32'h8000);
    chk("asl_flags", {24'd0, flags}, 32'h2A);
    step(ACC | LSL, 16'hC001, 16'h0);
    chk("lsl_res", {16'd0, alu_out}, 32'h8002);
    chk("lsl_flags", {24'd0, flags}, 32'h26);
    step(ACC | NOT, 16'hFFFF, 16'h0);
    chk("not_res", {16'd0, alu_out}, 32'h0000);
    chk("not_flags", {24'd0, flags}, 32'h21);

    // -5 * 300 with add + latch bits injected throughout (incl. completion edge)
    step(ACC | BR | MPY, 16'hFFFB, 16'h012C);
    n_busy = busy ? 1 : 0;
    chk("mpy_hold_alu", {16'd0, alu_out}, 32'h0000);
    while (busy && n_busy < 40) begin
      step(ACC | BR | ADD, 16'h1111, 16'h2222);
      if (busy) n_busy++;
    end
    chk("busy_cycles", n_busy, 32'd16);
    chk("mpy_lo", {16'd0, alu_out}, 32'hFA24);
    chk("mpy_hi", {16'd0, mr_out}, 32'hFFFF);
    chk("mpy_flags", {24'd0, flags}, 32'h22);
    step(NOT, 16'h0, 16'h0);
    chk("a_unchanged", {16'd0, alu_out}, 32'h0004);
    chk("mr_held", {16'd0, mr_out}, 32'hFFFF);

    // Asynchronous reset during the 8th multiply cycle
    step(ACC | BR | MPY, 16'h0003, 16'h0005);
    repeat (7) step(32'd0, 16'h0, 16'h0);
    chk("busy_before_rst", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_alu", {16'd0, alu_out}, 32'h0);
    chk("arst_mr", {16'd0, mr_out}, 32'h0);
    chk("arst_flags", {24'd0, flags}, 32'h0);
    @(negedge clk); #1;
    rst = 1'b1;
    n_done = 0;
    repeat (20) begin
      step(32'd0, 16'h0, 16'h0);
      if (flags[5]) n_done++;
    end
    chk("no_done_after_rst", n_done, 32'd0);

    // Extreme and zero products
    run_mpy(16'h8000, 16'h8000);
    chk("mn_lo", {16'd0, alu_out}, 32'h0000);
    chk("mn_hi", {16'd0, mr_out}, 32'h4000);
    chk("mn_flags", {24'd0, flags}, 32'h20);
    run_mpy(16'h0000, 16'h1234);
    chk("zero_prod", {16'd0, mr_out, alu_out}, 32'h0000);
    chk("zero_flags", {24'd0, flags}, 32'h21);
    run_mpy(16'h7FFF, 16'h8000);
    chk("mix_prod", {mr_out, alu_out}, 32'hC0008000);

    // Conflicting op bits: or wins, illegal set, then cleared
    step(ACC | BR | ADD | OR, 16'h00F0, 16'h0F0F);
    chk("multi_res", {16'd0, alu_out}, 32'h0FFF);
    chk("multi_flags", {24'd0, flags}, 32'h60);
    step(32'd0, 16'h0, 16'h0);
    chk("ill_holds", {24'd0, flags}, 32'h40);
    step(AND, 16'h0, 16'h0);
    chk("ill_clear_res", {16'd0, alu_out}, 32'h0000);
    chk("ill_clear_flags", {24'd0, flags}, 32'h21);
    step(32'd0, 16'h0, 16'h0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
